pc_branch_unit: RTL



---
 rtl/pc_branch_pkg.sv | 17 +
 rtl/pc_return_stack.sv | 43 ++++
 rtl/pc_branch_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pc_branch_pkg.sv
// pc_branch_pkg: shared types and flag bit positions for the branch unit
package pc_branch_pkg;
  typedef enum logic [2:0] {
    J_JUMP = 3'b000,
    J_JE   = 3'b001,
    J_JA   = 3'b010,
    J_JB   = 3'b011,
    J_JAE  = 3'b100,
    J_JBE  = 3'b101,
    J_CALL = 3'b110,
    J_RET  = 3'b111
  } jump_cond_e;
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_e;
  localparam int FLAG_ABOVE = 2;
  localparam int FLAG_EQUAL = 1;
  localparam int FLAG_BELOW = 0;
endpackage

// File: rtl/pc_return_stack.sv
// pc_return_stack: circular return-address LIFO; a push when full overwrites the oldest entry
module pc_return_stack #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty,
  output logic         err
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] sp_q, sp_d;
  logic [PW:0] cnt_q, cnt_d;
  assign full     = cnt_q == (PW+1)'(DEPTH);
  assign empty    = cnt_q == '0;
  assign err      = (push && full) || (pop && empty);
  assign pop_data = mem_q[sp_q - 1'b1];
  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    if (clr) begin
      sp_d  = '0;
      cnt_d = '0;
    end else if (push) begin
      sp_d  = sp_q + 1'b1;
      cnt_d = full ? cnt_q : cnt_q + 1'b1;
    end else if (pop && !empty) begin
      sp_d  = sp_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    sp_q  <= sp_d;
    cnt_q <= cnt_d;
    if (push && !clr) mem_q[sp_q] <= push_data;
  end
endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: sequenced PC with flag register and conditional jumps.
// Define PC_CALL_STACK_EN to add CALL/RET through a return stack.
module pc_branch_unit
  import pc_branch_pkg::*;
#(
  parameter int              ADDR_W      = 10,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int              STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              halt,
  input  logic              stall,
  input  logic              cmp_valid,
  input  logic [2:0]        cmp_flags,
  input  logic              jump_valid,
  input  logic [2:0]        jump_cond,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] pc,
  output logic              running,
  output logic [2:0]        flags,
  output logic              taken,
  output logic              illegal,
  output logic              stack_err
);
  if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("STACK_DEPTH must be a power of two and at least 2");
  end
  state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [2:0] flags_q, flags_d;
  logic taken_q, taken_d, illegal_q, illegal_d, stack_err_q, stack_err_d;
  jump_cond_e cond;
  function automatic logic cond_ok(input jump_cond_e c, input logic [2:0] f);
    return c == J_JUMP ? 1'b1 :
           c == J_JE   ? f[FLAG_EQUAL] :
           c == J_JA   ? f[FLAG_ABOVE] :
           c == J_JB   ? f[FLAG_BELOW] :
           c == J_JAE  ? f[FLAG_ABOVE] | f[FLAG_EQUAL] :
           c == J_JBE  ? f[FLAG_BELOW] | f[FLAG_EQUAL] : 1'b0;
  endfunction
  assign cond      = jump_cond_e'(jump_cond);
  assign pc_inc    = pc_q + 1'b1;
  assign pc        = pc_q;
  assign running   = state_q == RUN;
  assign flags     = flags_q;
  assign taken     = taken_q;
  assign illegal   = illegal_q;
  assign stack_err = stack_err_q;
`ifdef PC_CALL_STACK_EN
  logic push, pop, stk_full, stk_empty, stk_err, stk_clr;
  logic [ADDR_W-1:0] stk_top;
  assign stk_clr = !reset_n || (state_q != RUN && state_d == RUN);
  pc_return_stack #(.W(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk), .clr(stk_clr), .push(push), .pop(pop), .push_data(pc_inc),
    .pop_data(stk_top), .full(stk_full), .empty(stk_empty), .err(stk_err)
  );
`endif
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flags_d     = flags_q;
    taken_d     = 1'b0;
    illegal_d   = 1'b0;
    stack_err_d = stack_err_q;
`ifdef PC_CALL_STACK_EN
    push = 1'b0;
    pop  = 1'b0;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        pc_d    = RESET_VEC;
      end
      HALTED: if (start && !halt) begin
        state_d = RUN;
        pc_d    = RESET_VEC;
        flags_d = '0;
      end
      RUN: if (halt) state_d = HALTED;
      else if (!stall) begin
        if (cmp_valid) begin
          if (cmp_flags == 3'b100 || cmp_flags == 3'b010 || cmp_flags == 3'b001) flags_d = cmp_flags;
          else illegal_d = 1'b1;
        end
        pc_d = pc_inc;
        if (jump_valid) begin
          if (cond == J_CALL || cond == J_RET) begin
`ifdef PC_CALL_STACK_EN
            if (cond == J_CALL) begin
              push    = 1'b1;
              pc_d    = jump_target;
              taken_d = 1'b1;
            end else begin
              pop = 1'b1;
              if (!stk_empty) begin
                pc_d    = stk_top;
                taken_d = 1'b1;
              end
            end
            if (stk_err) stack_err_d = 1'b1;
            // stk_full is folded into stk_err; kept visible for debug probes
            if (stk_full && 1'b0) stack_err_d = 1'b1;
`else
            illegal_d = 1'b1;
`endif
          end else if (cond_ok(cond, flags_q)) begin
            pc_d    = jump_target;
            taken_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_VEC;
      flags_q     <= '0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
      stack_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      flags_q     <= flags_d;
      taken_q     <= taken_d;
      illegal_q   <= illegal_d;
      stack_err_q <= stack_err_d;
    end
  end
endmodule
